fsm_mem_check: RTL and testbench
================================

Name: fsm_mem_check

Overview:
- Parametrised write/read-back memory self-test controller. It is the successor to the single-width, single-pattern fixed-depth check FSM.
- On a start pulse it fills an internal RAM with a selectable data pattern, reads the RAM back and compares every word against the regenerated pattern.
- It repeats for a programmable number of passes, or until stopped.
- Reports a sticky error flag, a saturating error count and the first failing address.
- Used as a stand-alone BIST block in the FPGA learning designs.

Parameters:
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, RAM word width.
- CNT_W, 16, width of the error counter.

Ports:
- sclk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- write_start  in  1  start pulse; accepted only in IDLE.
- mode  in  2  pattern select; latched on accepted start.
- loop_num  in  8  number of passes; 0 = continuous until stop; latched on accepted start.
- stop  in  1  request to end after the current pass.
- inj_err  in  1  fault injection; flips the LSB of the read word for one compare.
- busy  out  1  high in WRITE, READ and DRAIN.
- done  out  1  one-cycle pulse at the end of the test.
- error_flag  out  1  sticky mismatch flag.
- err_cnt  out  CNT_W  saturating mismatch count.
- err_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, error_flag = 0; err_cnt = 0; err_addr = 0; pass counter = 0; stop request cleared.
  - RAM contents are not reset.
  - Reset mid-operation aborts immediately; no done pulse is generated.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - write_start=1 at a rising edge goes to WRITE with addr=0 and pass=0.
  - On that same edge: latch mode and loop_num; clear error_flag, err_cnt, err_addr and the stop request.
- WRITE:
  - RAM we=1, wdata=pattern(addr, pass); addr increments every cycle.
  - At addr=DEPTH-1, go to READ with addr=0. Duration is DEPTH cycles.
- READ:
  - Issue read addr and increment addr every cycle.
  - The RAM has a registered read with 1-cycle latency; the compare happens in the following cycle against pattern(delayed addr, pass).
  - At addr=DEPTH-1, go to DRAIN. Duration is DEPTH cycles.
- DRAIN:
  - One cycle, for the compare of address DEPTH-1.
  - Then go to DONE if (loop_num!=0 and pass+1==loop_num) or a stop request is pending.
  - Otherwise go to WRITE with pass+1 and addr=0.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
- Timing: one pass takes 2*DEPTH+1 busy cycles. done asserts one cycle after the final DRAIN.
- Patterns; a(x) is the address zero-extended or truncated to DATA_W:
  - mode 0: a(addr).
  - mode 1: ~a(addr).
  - mode 2: {DATA_W/2{2'b01}} when addr is even, {DATA_W/2{2'b10}} when addr is odd.
  - mode 3: a(addr) on even passes, ~a(addr) on odd passes.
- Compare:
  - A mismatch increments err_cnt, saturating at all-ones, and sets error_flag.
  - If error_flag was 0 before the mismatch, err_addr captures the address.
- inj_err:
  - Sampled in the READ cycle that issues address A; it corrupts only the compare of A.
  - Ignored in every other state.
- stop:
  - Sampled in any busy cycle; sets a sticky stop request.
  - The current pass always completes.
  - stop in IDLE is ignored.
- write_start while busy or in DONE is ignored.
- The pass counter is 8 bits. For loop_num=0 it wraps freely, which only affects the mode 3 parity.

Decomposition:
- Package fsm_mem_check_pkg holds:
  - state encoding constants (IDLE..DONE);
  - mode constants (MODE_ADDR, MODE_INV, MODE_CHK, MODE_MARCH);
  - pattern-generation function pattern(addr, pass, mode).
- One sub-module, sp_ram_sync:
  - parameters ADDR_W and DATA_W;
  - ports sclk, we, addr, wdata, rdata;
  - registered read, no reset on the array.

Test Plan (ADDR_W=4, DATA_W=8, CNT_W=16 unless stated):
1. mode 0, loop_num=1, single start pulse -> busy high for 33 cycles, then done for 1 cycle; error_flag=0, err_cnt=0.
2. mode 0, loop_num=1, inj_err high in the READ cycles for addresses 3 and 9 -> err_cnt=2, err_addr=3, error_flag=1 after done.
3. mode 3, loop_num=2 -> the second WRITE pass writes ~addr (addr 5 = 0xFA); 66 busy cycles; no error; exactly one done.
4. loop_num=0, stop pulsed in the READ phase of pass 1 -> pass 1 finishes, done pulses, busy total 66 cycles; the next start clears the previous error_flag.
5. write_start pulsed during busy -> ignored and the test length is unchanged. rst_n low mid-READ -> busy, done, error_flag and err_cnt drop to 0 asynchronously; a fresh start after release runs cleanly.
6. CNT_W=4, loop_num=2, inj_err held high through both READ phases -> err_cnt saturates at 15; err_addr=0.

Source files
------------

// File: rtl/fsm_mem_check_pkg.sv
// fsm_mem_check_pkg: state/mode encodings and the pattern generator shared by the memory self-test
package fsm_mem_check_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_ADDR  = 2'd0;
    localparam logic [1:0] MODE_INV   = 2'd1;
    localparam logic [1:0] MODE_CHK   = 2'd2;
    localparam logic [1:0] MODE_MARCH = 2'd3;

    // Patterns are built at this width and truncated by the caller to its word width
    localparam int PAT_W = 64;

    function automatic logic [PAT_W-1:0] pattern(
        input logic [PAT_W-1:0] addr,
        input logic [7:0]       pass,
        input logic [1:0]       mode
    );
        logic [PAT_W-1:0] chk;
        logic             odd_pass;
        chk      = addr[0] ? {(PAT_W/2){2'b10}} : {(PAT_W/2){2'b01}};
        odd_pass = (pass & 8'd1) != 8'd0;
        return (mode == MODE_CHK) ? chk :
               ((mode == MODE_INV) || ((mode == MODE_MARCH) && odd_pass)) ? ~addr : addr;
    endfunction

endpackage

// File: rtl/fsm_mem_check_sp_ram_sync.sv
// sp_ram_sync: single-port RAM with registered read and an unreset array
module sp_ram_sync #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              sclk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write when enabled; read data appears one cycle after the address
    always_ff @(posedge sclk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/fsm_mem_check.sv
// fsm_mem_check: write/read-back RAM self-test with selectable patterns, pass looping and error reporting
module fsm_mem_check
    import fsm_mem_check_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              write_start,
    input  logic [1:0]        mode,
    input  logic [7:0]        loop_num,
    input  logic              stop,
    input  logic              inj_err,
    output logic              busy,
    output logic              done,
    output logic              error_flag,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] err_addr
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          pass_q, pass_d;
    logic [1:0]          mode_q;
    logic [7:0]          loop_q;
    logic                stop_q;
    logic                cmp_vld_q;
    logic [ADDR_W-1:0]   cmp_addr_q;
    logic                inj_q;
    logic                err_flag_q;
    logic [CNT_W-1:0]    err_cnt_q;
    logic [ADDR_W-1:0]   err_addr_q;
    logic                we;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic [DATA_W-1:0]   exp_rd;
    logic                start;
    logic                last;
    logic                finish;
    logic                mismatch;

    assign start    = (state_q == IDLE) && write_start;
    assign last     = &addr_q;
    // A stop arriving in the DRAIN cycle itself still ends the test after this pass
    assign finish   = ((loop_q != 8'd0) && (pass_q + 8'd1 == loop_q)) || stop_q || stop;
    assign exp_rd   = DATA_W'(pattern(PAT_W'(cmp_addr_q), pass_q, mode_q));
    assign mismatch = cmp_vld_q && ((rdata ^ DATA_W'(inj_q)) != exp_rd);

    assign error_flag = err_flag_q;
    assign err_cnt    = err_cnt_q;
    assign err_addr   = err_addr_q;

    sp_ram_sync #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .sclk (sclk),
        .we   (we),
        .addr (addr_q),
        .wdata(wdata),
        .rdata(rdata)
    );

    // State register
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state plus address and pass sequencing; the address wraps to 0 at the end of each sweep
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (write_start) state_d = WRITE;
            WRITE:   if (last) state_d = READ;
            READ:    if (last) state_d = DRAIN;
            DRAIN:   state_d = finish ? DONE : WRITE;
            default: state_d = IDLE;
        endcase
        addr_d = ((state_q == WRITE) || (state_q == READ)) ? addr_q + 1'b1 : '0;
        pass_d = start ? 8'd0 : ((state_q == DRAIN) && !finish) ? pass_q + 8'd1 : pass_q;
    end

    // Status outputs and RAM write port
    always_comb begin
        busy  = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
        done  = state_q == DONE;
        we    = state_q == WRITE;
        wdata = DATA_W'(pattern(PAT_W'(addr_q), pass_q, mode_q));
    end

    // Sequencing registers, start-time configuration latch and sticky stop request
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            pass_q <= '0;
            mode_q <= '0;
            loop_q <= '0;
            stop_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            pass_q <= pass_d;
            if (start) begin
                mode_q <= mode;
                loop_q <= loop_num;
            end
            stop_q <= start ? 1'b0 : (stop_q | (busy & stop));
        end
    end

    // Read-back compare one cycle behind the issued address, with error accounting
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
            inj_q      <= 1'b0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            cmp_vld_q  <= state_q == READ;
            cmp_addr_q <= addr_q;
            inj_q      <= inj_err && (state_q == READ);
            if (start) begin
                err_flag_q <= 1'b0;
                err_cnt_q  <= '0;
                err_addr_q <= '0;
            end else if (mismatch) begin
                err_flag_q <= 1'b1;
                err_cnt_q  <= (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
                err_addr_q <= err_flag_q ? err_addr_q : cmp_addr_q;
            end
        end
    end

endmodule

// File: tb/tb_fsm_mem_check.sv
// tb_fsm_mem_check: randomized directed runs of the memory self-test checked against a pass/cycle model
module tb_fsm_mem_check;

    localparam int AW       = 4;
    localparam int DW       = 8;
    localparam int DEPTH    = 16;
    localparam int PASS_LEN = 2 * DEPTH + 1;

    logic        sclk;
    logic        rst_n;
    logic        write_start;
    logic [1:0]  mode;
    logic [7:0]  loop_num;
    logic        stop;
    logic        inj_err;
    logic        busy, done, error_flag;
    logic [15:0] err_cnt;
    logic [AW-1:0] err_addr;
    logic        busy_s, done_s, error_flag_s;
    logic [3:0]  err_cnt_s;
    logic [AW-1:0] err_addr_s;

    int n_assert = 0;
    int n_fail   = 0;

    fsm_mem_check #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
        .sclk(sclk), .rst_n(rst_n), .write_start(write_start), .mode(mode),
        .loop_num(loop_num), .stop(stop), .inj_err(inj_err), .busy(busy),
        .done(done), .error_flag(error_flag), .err_cnt(err_cnt), .err_addr(err_addr)
    );

    fsm_mem_check #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut_s (
        .sclk(sclk), .rst_n(rst_n), .write_start(write_start), .mode(mode),
        .loop_num(loop_num), .stop(stop), .inj_err(inj_err), .busy(busy_s),
        .done(done_s), .error_flag(error_flag_s), .err_cnt(err_cnt_s), .err_addr(err_addr_s)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_word(input int m, input int a, input int p);
        case (m)
            0:       return 8'(a);
            1:       return 8'(255 - a);
            2:       return (a % 2 == 1) ? 8'hAA : 8'h55;
            default: return (p % 2 == 1) ? 8'(255 - a) : 8'(a);
        endcase
    endfunction

    // One complete test: the model knows each pass is WRITE(16) READ(16) DRAIN(1) and
    // that address a of pass p is read in cycle p*33+16+a counted from the first WRITE cycle
    task automatic run(input int m, input int loops, input int stop_pass,
                       input logic [15:0] mask, input bit rnd, input bit spam);
        int passes, exp_len, t, n_err, first, p, r;
        passes = (loops != 0) ? loops : stop_pass + 1;
        if (loops != 0 && stop_pass >= 0 && stop_pass + 1 < loops)
            passes = stop_pass + 1;
        exp_len = passes * PASS_LEN;
        mode = 2'(m);
        loop_num = 8'(loops);
        write_start = 1'b1;
        @(posedge sclk);
        #1;
        write_start = 1'b0;
        mode = 2'($urandom);
        loop_num = 8'($urandom);
        chk("start_clears_flag", {31'd0, error_flag}, 32'd0);
        chk("start_clears_cnt", {16'd0, err_cnt}, 32'd0);
        t = 0;
        n_err = 0;
        first = -1;
        while (busy === 1'b1 && t < exp_len + 10) begin
            p = t / PASS_LEN;
            r = t % PASS_LEN;
            if (r >= DEPTH && r < 2 * DEPTH) begin
                inj_err = mask[r-DEPTH] | (rnd && $urandom_range(3) == 0);
                if (inj_err) begin
                    n_err++;
                    if (first < 0) first = r - DEPTH;
                end
            end else
                inj_err = rnd ? 1'($urandom_range(1)) : 1'b0;
            stop = (stop_pass >= 0) && (p == stop_pass) && (r == DEPTH + 4);
            write_start = spam ? 1'($urandom_range(1)) : 1'b0;
            @(posedge sclk);
            #1;
            t++;
        end
        inj_err = 1'b0;
        stop = 1'b0;
        write_start = 1'b0;
        chk("busy_len", t, exp_len);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        chk("error_flag", {31'd0, error_flag}, (n_err > 0) ? 32'd1 : 32'd0);
        chk("err_cnt", {16'd0, err_cnt}, (n_err > 65535) ? 32'd65535 : n_err);
        chk("err_cnt_sat4", {28'd0, err_cnt_s}, (n_err > 15) ? 32'd15 : n_err);
        chk("err_addr", {28'd0, err_addr}, (first < 0) ? 32'd0 : first);
        @(posedge sclk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        for (int a = 0; a < DEPTH; a++)
            chk($sformatf("ram[%0d]", a), {24'd0, dut.u_ram.mem[a]}, {24'd0, ref_word(m, a, passes - 1)});
    endtask

    initial begin
        rst_n = 1'b0;
        write_start = 1'b0;
        mode = 2'd0;
        loop_num = 8'd0;
        stop = 1'b0;
        inj_err = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_flag", {31'd0, error_flag}, 32'd0);
        chk("rst_cnt", {16'd0, err_cnt}, 32'd0);
        chk("rst_addr", {28'd0, err_addr}, 32'd0);
        @(negedge sclk);
        rst_n = 1'b1;
        @(posedge sclk);
        #1;
        stop = 1'b1;
        @(posedge sclk);
        #1;
        stop = 1'b0;
        chk("idle_stays_idle", {31'd0, busy}, 32'd0);

        run(0, 1, -1, 16'h0000, 1'b0, 1'b0);
        run(0, 1, -1, 16'h0208, 1'b0, 1'b0);
        run(3, 2, -1, 16'h0000, 1'b0, 1'b0);
        run(1, 0, 1, 16'h0000, 1'b1, 1'b0);
        run(2, 3, -1, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            run(int'($urandom_range(3)), int'($urandom_range(3, 1)), -1, 16'($urandom), 1'b1, 1'b1);
        run(0, 2, -1, 16'hFFFF, 1'b0, 1'b0);
        run(3, 0, 2, 16'h0000, 1'b0, 1'b0);

        mode = 2'd0;
        loop_num = 8'd1;
        write_start = 1'b1;
        @(posedge sclk);
        #1;
        write_start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            inj_err = (t >= DEPTH);
            @(posedge sclk);
            #1;
        end
        inj_err = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_flag", {31'd0, error_flag}, 32'd1);
        chk("pre_rst_cnt", {16'd0, err_cnt}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_flag", {31'd0, error_flag}, 32'd0);
        chk("async_rst_cnt", {16'd0, err_cnt}, 32'd0);
        chk("async_rst_cnt4", {28'd0, err_cnt_s}, 32'd0);
        @(negedge sclk);
        rst_n = 1'b1;
        @(posedge sclk);
        #1;
        chk("post_rst_no_done", {31'd0, done}, 32'd0);
        run(3, 1, -1, 16'h0000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
